// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: widths, ALU codes, alu_op encodings, forward selects
package cpu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_DEF   = 5;

  // ALU control codes, shared with the ALU.
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_ADDI = 3'b110;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  // alu_op encodings produced by the main decoder.
  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IARITH = 2'b11;

  // Operand source selects from the forwarding unit.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Any combination not listed falls back to ADD.
  function automatic logic [2:0] alu_decode(input logic [1:0] op,
                                            input logic [6:0] f7,
                                            input logic [2:0] f3);
    logic [2:0] code;
    code = ALU_ADD;
    case (op)
      ALUOP_BRANCH: code = ALU_SUB;
      ALUOP_RTYPE: begin
        case ({f7, f3})
          10'b0000000_111: code = ALU_AND;
          10'b0000000_100: code = ALU_XOR;
          10'b0000000_001: code = ALU_SLL;
          10'b0000000_000: code = ALU_ADD;
          10'b0100000_000: code = ALU_SUB;
          10'b0000001_000: code = ALU_MUL;
          default:         code = ALU_ADD;
        endcase
      end
      ALUOP_IARITH: begin
        // funct7 of an ADDI is immediate bits, so only funct3 matters there.
        if (f3 == 3'b000)
          code = ALU_ADDI;
        else if (f3 == 3'b101 && f7 == 7'b0100000)
          code = ALU_SRAI;
        else
          code = ALU_ADD;
      end
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - combinational operand source select for EX-stage forwarding
// Ports:
//   rs1_addr_i, rs2_addr_i      : source registers of the instruction held in EX
//   exmem_regwrite_i/exmem_rd_i : EX/MEM writeback candidate (highest priority)
//   memwb_regwrite_i/memwb_rd_i : MEM/WB writeback candidate
//   fwd1_sel_o, fwd2_sel_o      : 00 register file, 01 MEM/WB, 10 EX/MEM
module forward_unit
  import cpu_pkg::*;
#(
  parameter int RA = RA_DEF
) (
  input  logic [RA-1:0] rs1_addr_i,
  input  logic [RA-1:0] rs2_addr_i,
  input  logic          exmem_regwrite_i,
  input  logic [RA-1:0] exmem_rd_i,
  input  logic          memwb_regwrite_i,
  input  logic [RA-1:0] memwb_rd_i,
  output logic [1:0]    fwd1_sel_o,
  output logic [1:0]    fwd2_sel_o
);

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  function automatic logic [1:0] src_sel(input logic [RA-1:0] rs,
                                         input logic          em_we,
                                         input logic [RA-1:0] em_rd,
                                         input logic          mw_we,
                                         input logic [RA-1:0] mw_rd);
    logic [1:0] sel;
    sel = FWD_REG;
    if (em_we && em_rd != '0 && em_rd == rs)
      sel = FWD_EXMEM;
    else if (mw_we && mw_rd != '0 && mw_rd == rs)
      sel = FWD_MEMWB;
    return sel;
  endfunction

  always_comb begin
    fwd1_sel_o = src_sel(rs1_addr_i, exmem_regwrite_i, exmem_rd_i,
                         memwb_regwrite_i, memwb_rd_i);
    fwd2_sel_o = src_sel(rs2_addr_i, exmem_regwrite_i, exmem_rd_i,
                         memwb_regwrite_i, memwb_rd_i);
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU decode, forwarding and load-use detect
// Ports:
//   clk_i, rst_i (sync, active-high), stall_i (freeze), flush_i (bubble)
//   ID side  : valid_i, rs1/rs2_data_i, imm_i, rs1/rs2/rd_addr_i, alu_op_i,
//              funct7_i, funct3_i, alusrc/regwrite/memread/memwrite/memtoreg_i
//   forwarding: exmem_regwrite_i/rd_i/data_i, memwb_regwrite_i/rd_i/data_i
//   EX side  : data1_o, data2_o, store_data_o, alu_ctrl_o, rd_addr_o,
//              regwrite/memread/memwrite/memtoreg_o, valid_o
//   hazard_o : load-use stall request toward IF/ID and PC
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA   = RA_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [RA-1:0]   rs1_addr_i,
  input  logic [RA-1:0]   rs2_addr_i,
  input  logic [RA-1:0]   rd_addr_i,
  input  logic [1:0]      alu_op_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic            alusrc_i,
  input  logic            regwrite_i,
  input  logic            memread_i,
  input  logic            memwrite_i,
  input  logic            memtoreg_i,
  input  logic            exmem_regwrite_i,
  input  logic [RA-1:0]   exmem_rd_i,
  input  logic [XLEN-1:0] exmem_data_i,
  input  logic            memwb_regwrite_i,
  input  logic [RA-1:0]   memwb_rd_i,
  input  logic [XLEN-1:0] memwb_data_i,
  output logic [XLEN-1:0] data1_o,
  output logic [XLEN-1:0] data2_o,
  output logic [2:0]      alu_ctrl_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [RA-1:0]   rd_addr_o,
  output logic            regwrite_o,
  output logic            memread_o,
  output logic            memwrite_o,
  output logic            memtoreg_o,
  output logic            valid_o,
  output logic            hazard_o
);

  logic [RA-1:0]   rs1_addr_q;
  logic [RA-1:0]   rs2_addr_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic            alusrc_q;
  logic            bubble;
  logic [1:0]      fwd1_sel;
  logic [1:0]      fwd2_sel;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // A load in EX whose destination is read by the instruction in ID.
  assign hazard_o = valid_o & memread_o & (rd_addr_o != '0) & valid_i &
                    ((rd_addr_o == rs1_addr_i) | (rd_addr_o == rs2_addr_i));

  // Flush beats stall; a hazard bubble yields to a whole-pipeline freeze.
  assign bubble = flush_i | (hazard_o & ~stall_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || bubble) begin
      valid_o    <= 1'b0;
      regwrite_o <= 1'b0;
      memread_o  <= 1'b0;
      memwrite_o <= 1'b0;
      memtoreg_o <= 1'b0;
      alu_ctrl_o <= 3'b000;
      rd_addr_o  <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
    end else if (!stall_i) begin
      valid_o    <= valid_i;
      regwrite_o <= regwrite_i;
      memread_o  <= memread_i;
      memwrite_o <= memwrite_i;
      memtoreg_o <= memtoreg_i;
      alu_ctrl_o <= alu_decode(alu_op_i, funct7_i, funct3_i);
      rd_addr_o  <= rd_addr_i;
      rs1_addr_q <= rs1_addr_i;
      rs2_addr_q <= rs2_addr_i;
      rs1_data_q <= rs1_data_i;
      rs2_data_q <= rs2_data_i;
      imm_q      <= imm_i;
      alusrc_q   <= alusrc_i;
    end
  end

  forward_unit #(.RA(RA)) u_forward_unit (
    .rs1_addr_i       (rs1_addr_q),
    .rs2_addr_i       (rs2_addr_q),
    .exmem_regwrite_i (exmem_regwrite_i),
    .exmem_rd_i       (exmem_rd_i),
    .memwb_regwrite_i (memwb_regwrite_i),
    .memwb_rd_i       (memwb_rd_i),
    .fwd1_sel_o       (fwd1_sel),
    .fwd2_sel_o       (fwd2_sel)
  );

  // Operands stay combinational so a stalled stage sees live forwarding data.
  always_comb begin
    case (fwd1_sel)
      FWD_EXMEM: rs1_fwd = exmem_data_i;
      FWD_MEMWB: rs1_fwd = memwb_data_i;
      default:   rs1_fwd = rs1_data_q;
    endcase
    case (fwd2_sel)
      FWD_EXMEM: rs2_fwd = exmem_data_i;
      FWD_MEMWB: rs2_fwd = memwb_data_i;
      default:   rs2_fwd = rs2_data_q;
    endcase
  end

  assign data1_o      = rs1_fwd;
  assign store_data_o = rs2_fwd;
  assign data2_o      = alusrc_q ? imm_q : rs2_fwd;

endmodule
